aes_128_key_expand: RTL



---
 rtl/aes_128_key_expand.sv | 132 +++++++++++++
 1 files changed

// File: rtl/aes_128_key_expand.sv
// aes_128_key_expand: AES-128 key schedule streaming the key and round keys 1..10 into the key RAM as 64-bit half-words.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

module aes_128_key_expand #(
    parameter int N_ROUNDS   = 10,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  kill_n,
    input  logic                  key_start,
    input  logic [127:0]          key_in,
    input  logic                  abort,
    output logic                  busy,
    output logic                  en_wr,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [63:0]           key_round_wr,
    output logic                  expand_done
);
    localparam int RW = $clog2(N_ROUNDS + 1);
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;
    state_t                state, state_nx;
    logic [127:0]          key_reg, key_nx, key_next;
    logic [7:0]            rcon, rcon_nx, rcon_next;
    logic [RW-1:0]         round, round_nx, round_inc;
    logic [31:0]           w3_rot, sub_w, w4, w5, w6, w7;
    logic                  busy_nx, en_nx, done_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [63:0]           data_nx;
    assign w3_rot = {key_reg[103:96], key_reg[127:104]};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (.a(w3_rot[8*i +: 8]), .y(sub_w[8*i +: 8]));
        end
    endgenerate
    assign w4        = key_reg[31:0] ^ sub_w ^ {24'h0, rcon};
    assign w5        = key_reg[63:32] ^ w4;
    assign w6        = key_reg[95:64] ^ w5;
    assign w7        = key_reg[127:96] ^ w6;
    assign key_next  = {w7, w6, w5, w4};
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign round_inc = round + RW'(1);
    // Output registers are loaded with the values belonging to the state being entered.
    always_comb begin
        state_nx = state;
        key_nx   = key_reg;
        rcon_nx  = rcon;
        round_nx = round;
        en_nx    = 1'b0;
        done_nx  = 1'b0;
        addr_nx  = addr_wr;
        data_nx  = key_round_wr;
        case (state)
            IDLE: if (key_start) begin
                state_nx = WR_LO;
                key_nx   = key_in;
                rcon_nx  = 8'h01;
                round_nx = '0;
                en_nx    = 1'b1;
                addr_nx  = '0;
                data_nx  = key_in[63:0];
            end
            WR_LO: begin
                state_nx = WR_HI;
                en_nx    = 1'b1;
                addr_nx  = ADDR_WIDTH'({round, 1'b1});
                data_nx  = key_reg[127:64];
            end
            WR_HI: begin
                key_nx  = key_next;
                rcon_nx = rcon_next;
                if (round == RW'(N_ROUNDS)) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = WR_LO;
                    round_nx = round_inc;
                    en_nx    = 1'b1;
                    addr_nx  = ADDR_WIDTH'({round_inc, 1'b0});
                    data_nx  = key_next[63:0];
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            en_nx    = 1'b0;
            done_nx  = 1'b0;
            addr_nx  = addr_wr;
            data_nx  = key_round_wr;
        end
        busy_nx = (state_nx != IDLE);
    end
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state        <= IDLE;
            key_reg      <= '0;
            rcon         <= 8'h01;
            round        <= '0;
            busy         <= 1'b0;
            en_wr        <= 1'b0;
            expand_done  <= 1'b0;
            addr_wr      <= '0;
            key_round_wr <= '0;
        end else begin
            state        <= state_nx;
            key_reg      <= key_nx;
            rcon         <= rcon_nx;
            round        <= round_nx;
            busy         <= busy_nx;
            en_wr        <= en_nx;
            expand_done  <= done_nx;
            addr_wr      <= addr_nx;
            key_round_wr <= data_nx;
        end
    end
endmodule
